// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: assembles SOF|ADDR|LEN|PAYLOAD|CHK frames from the UART
// receiver byte stream, verifies the XOR checksum and replays the buffered
// payload as register writes over a valid/ready port.
module uart_frame_decoder #(
  parameter real        CPLD_CLK_Hz = 66_000_000.0,
  parameter int         TIMEOUT_US  = 2000,
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         MAX_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [3:0] ovr_cnt
);

  localparam int TIMEOUT_CLKS = int'(CPLD_CLK_Hz * TIMEOUT_US / 1.0e6);
  localparam int TW           = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int IW           = $clog2(MAX_LEN + 1);
  localparam int BUF_D        = 1 << IW;

  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_REPLAY
  } state_t;

  state_t          r_state;
  logic [7:0]      r_base;
  logic [IW-1:0]   r_len;
  logic [IW-1:0]   r_idx;
  logic [7:0]      r_chk;
  logic [TW-1:0]   r_tcnt;
  logic [7:0]      r_buf [BUF_D];
  logic            r_wrValid;
  logic [7:0]      r_wrAddr;
  logic [7:0]      r_wrData;
  logic            r_frameOk;
  logic            r_frameErr;
  logic [1:0]      r_errCode;
  logic [3:0]      r_ovr;

  logic [7:0]      w_byte;
  logic            w_rxParityUnused;
  logic            w_inFrame;
  logic            w_lastIdx;
  logic [IW-1:0]   w_nextIdx;

  // The receiver word carries the byte in the upper bits; bit 0 has no meaning here.
  assign w_byte           = rx_data[8:1];
  assign w_rxParityUnused = rx_data[0];
  assign w_inFrame        = (r_state == S_ADDR) || (r_state == S_LEN) ||
                            (r_state == S_PAYLOAD) || (r_state == S_CHK);
  assign w_lastIdx        = (r_idx == (r_len - IDX_ONE));
  assign w_nextIdx        = r_idx + IDX_ONE;

  // Frame FSM: byte assembly, inter-byte timeout, checksum and payload replay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_chk      <= '0;
      r_tcnt     <= '0;
      r_wrValid  <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
      r_frameOk  <= 1'b0;
      r_frameErr <= 1'b0;
      r_errCode  <= '0;
      r_ovr      <= '0;
      for (int i = 0; i < BUF_D; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_frameOk  <= 1'b0;
      r_frameErr <= 1'b0;

      if (w_inFrame && !rx_valid) begin
        if (r_tcnt == TOUT_LAST) begin
          r_frameErr <= 1'b1;
          r_errCode  <= ERR_TOUT;
          r_state    <= S_IDLE;
          r_tcnt     <= '0;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end else begin
        r_tcnt <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (rx_valid && (w_byte == SOF_BYTE)) begin
            r_chk   <= '0;
            r_state <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            r_base  <= w_byte;
            r_chk   <= r_chk ^ w_byte;
            r_state <= S_LEN;
          end
        end

        S_LEN: begin
          if (rx_valid) begin
            r_chk <= r_chk ^ w_byte;
            if ((w_byte == 8'd0) || (w_byte > MAX_LEN_B)) begin
              r_frameErr <= 1'b1;
              r_errCode  <= ERR_LEN;
              r_state    <= S_IDLE;
            end else begin
              r_len   <= w_byte[IW-1:0];
              r_idx   <= '0;
              r_state <= S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD: begin
          if (rx_valid) begin
            r_buf[r_idx] <= w_byte;
            r_chk        <= r_chk ^ w_byte;
            if (w_lastIdx) begin
              r_state <= S_CHK;
            end else begin
              r_idx <= w_nextIdx;
            end
          end
        end

        S_CHK: begin
          if (rx_valid) begin
            if (w_byte == r_chk) begin
              r_idx     <= '0;
              r_wrValid <= 1'b1;
              r_wrAddr  <= r_base;
              r_wrData  <= r_buf[0];
              r_state   <= S_REPLAY;
            end else begin
              r_frameErr <= 1'b1;
              r_errCode  <= ERR_CHK;
              r_state    <= S_IDLE;
            end
          end
        end

        S_REPLAY: begin
          if (rx_valid && (r_ovr != 4'hF)) begin
            r_ovr <= r_ovr + 4'd1;
          end
          if (r_wrValid && wr_ready) begin
            if (w_lastIdx) begin
              r_wrValid <= 1'b0;
              r_frameOk <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_idx    <= w_nextIdx;
              r_wrAddr <= r_base + 8'(w_nextIdx);
              r_wrData <= r_buf[w_nextIdx];
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_valid  = r_wrValid;
  assign wr_addr   = r_wrAddr;
  assign wr_data   = r_wrData;
  assign frame_ok  = r_frameOk;
  assign frame_err = r_frameErr;
  assign err_code  = r_errCode;
  assign ovr_cnt   = r_ovr;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: directed frame scenarios plus randomized frames checked
// against a frame-level reference model (expected write list, pulse counts, codes).
module tb_uart_frame_decoder;

  localparam real        TB_CLK_HZ  = 1_000_000.0;
  localparam int         TB_TOUT_US = 40;
  localparam int         TB_TCLKS   = TB_TOUT_US * int'(TB_CLK_HZ / 1.0e6);
  localparam int         TB_MAX_LEN = 8;
  localparam logic [7:0] SOF        = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       wr_ready = 1'b1;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
  logic [3:0] ovr_cnt;

  int checks = 0;
  int failures = 0;
  int okCnt = 0;
  int errCnt = 0;
  int bothCnt = 0;
  int ovrModel = 0;
  logic [15:0] expQ[$];
  logic [15:0] obsQ[$];

  uart_frame_decoder #(
    .CPLD_CLK_Hz (TB_CLK_HZ),
    .TIMEOUT_US  (TB_TOUT_US),
    .SOF_BYTE    (SOF),
    .MAX_LEN     (TB_MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy),
    .ovr_cnt   (ovr_cnt)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Observe accepted writes and result pulses on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid && wr_ready) obsQ.push_back({wr_addr, wr_data});
      if (frame_ok) okCnt++;
      if (frame_err) errCnt++;
      if (frame_ok && frame_err) bothCnt++;
    end
  end

  // Stop a hung run with a visible failure.
  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: observed=still_running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = {b, 1'($urandom)};
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 9'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic gap();
    idle($urandom_range(0, 2));
  endtask

  task automatic startFrame();
    expQ.delete();
    obsQ.delete();
    okCnt  = 0;
    errCnt = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ctl"}, {wr_valid, frame_ok, frame_err, busy}, 4'b0000);
    checkOutput({tag, "_code"}, err_code, 2'b00);
    checkOutput({tag, "_ovr"}, ovr_cnt, 4'd0);
    checkOutput({tag, "_wr"}, {wr_addr, wr_data}, 16'h0000);
  endtask

  task automatic finishFrame(input int expOk, input int expErr, input logic [1:0] expCode,
                             input bit randReady, input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (randReady) wr_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    wr_ready = 1'b1;
    idle(2);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_wcount"}, obsQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      checkOutput({tag, "_write"}, obsQ[i], expQ[i]);
    end
    checkOutput({tag, "_okcnt"}, okCnt, expOk);
    checkOutput({tag, "_errcnt"}, errCnt, expErr);
    if (expErr != 0) checkOutput({tag, "_errcode"}, err_code, expCode);
  endtask

  task automatic runFrame(input logic [7:0] addr, input logic [7:0] lenB, input bit corrupt,
                          input bit randReady, input string tag);
    logic [7:0] pl[$];
    logic [7:0] chk;
    logic [7:0] b;
    startFrame();
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      if (b == SOF) b = 8'h5A;
      applyStimulus(b);
    end
    applyStimulus(SOF); gap();
    applyStimulus(addr); gap();
    applyStimulus(lenB);
    if (lenB == 0 || lenB > TB_MAX_LEN) begin
      finishFrame(0, 1, 2'b01, randReady, tag);
      return;
    end
    chk = addr ^ lenB;
    for (int i = 0; i < lenB; i++) begin
      b = 8'($urandom_range(0, 255));
      pl.push_back(b);
      chk ^= b;
      gap();
      applyStimulus(b);
    end
    if (corrupt) chk ^= 8'($urandom_range(1, 255));
    gap();
    applyStimulus(chk);
    if (!corrupt) begin
      for (int i = 0; i < lenB; i++) expQ.push_back({8'(addr + i), pl[i]});
    end
    finishFrame(corrupt ? 0 : 1, corrupt ? 1 : 0, 2'b10, randReady, tag);
  endtask

  task automatic stalledFrame(input logic [7:0] addr, input int nInj, input string tag);
    logic [7:0] pl[3];
    logic [7:0] chk;
    startFrame();
    wr_ready = 1'b0;
    chk = addr ^ 8'd3;
    for (int i = 0; i < 3; i++) begin
      pl[i] = 8'($urandom_range(0, 255));
      chk ^= pl[i];
    end
    applyStimulus(SOF);
    applyStimulus(addr);
    applyStimulus(8'd3);
    for (int i = 0; i < 3; i++) applyStimulus(pl[i]);
    applyStimulus(chk);
    for (int i = 0; i < nInj + 2; i++) begin
      rx_data  = 9'($urandom);
      rx_valid = (i < nInj);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      checkOutput({tag, "_hold"}, {wr_valid, wr_addr, wr_data}, {1'b1, addr, pl[0]});
    end
    ovrModel = (ovrModel + nInj > 15) ? 15 : ovrModel + nInj;
    checkOutput({tag, "_ovr"}, ovr_cnt, ovrModel);
    wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) expQ.push_back({8'(addr + i), pl[i]});
    finishFrame(1, 0, 2'b00, 1'b0, tag);
  endtask

  // Directed scenarios followed by randomized frames.
  initial begin
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good frame, back-to-back writes, one-clock replay latency.
    startFrame();
    applyStimulus(SOF);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h65);
    checkOutput("t1_first_valid", wr_valid, 1);
    checkOutput("t1_first_write", {wr_addr, wr_data}, 16'h1033);
    @(posedge clk); #1;
    checkOutput("t1_second_valid", wr_valid, 1);
    checkOutput("t1_second_write", {wr_addr, wr_data}, 16'h1144);
    @(posedge clk); #1;
    checkOutput("t1_end_valid", wr_valid, 0);
    checkOutput("t1_ok_pulse", frame_ok, 1);
    expQ.push_back(16'h1033);
    expQ.push_back(16'h1144);
    finishFrame(1, 0, 2'b00, 1'b0, "t1");

    // Bad checksum.
    startFrame();
    applyStimulus(SOF);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h66);
    checkOutput("t2_err_pulse", {frame_err, err_code, wr_valid, busy}, 5'b1_10_0_0);
    finishFrame(0, 1, 2'b10, 1'b0, "t2");

    // Bad lengths at both ends, then boundary-valid lengths.
    startFrame();
    applyStimulus(SOF);
    applyStimulus(8'h20);
    applyStimulus(8'h00);
    checkOutput("t3_len0", {frame_err, err_code}, 3'b1_01);
    finishFrame(0, 1, 2'b01, 1'b0, "t3_len0");
    startFrame();
    applyStimulus(SOF);
    applyStimulus(8'h20);
    applyStimulus(8'h09);
    checkOutput("t3_len9", {frame_err, err_code}, 3'b1_01);
    finishFrame(0, 1, 2'b01, 1'b0, "t3_len9");
    runFrame(8'h20, 8'd8, 1'b0, 1'b0, "t3_len8");
    runFrame(8'h21, 8'd1, 1'b0, 1'b0, "t3_len1");

    // Inter-byte timeout, exactly at expiry.
    startFrame();
    applyStimulus(SOF);
    applyStimulus(8'h30);
    idle(TB_TCLKS - 1);
    checkOutput("t4_before_expiry", {frame_err, busy}, 2'b01);
    idle(1);
    checkOutput("t4_expiry", {frame_err, err_code, busy}, 4'b1_11_0);
    finishFrame(0, 1, 2'b11, 1'b0, "t4");

    // A byte arriving in the expiry cycle keeps the frame alive.
    startFrame();
    applyStimulus(SOF);
    applyStimulus(8'h30);
    idle(TB_TCLKS - 1);
    applyStimulus(8'h01);
    checkOutput("t4_edge_alive", {frame_err, busy}, 2'b01);
    applyStimulus(8'h77);
    applyStimulus(8'h30 ^ 8'h01 ^ 8'h77);
    expQ.push_back({8'h30, 8'h77});
    finishFrame(1, 0, 2'b00, 1'b0, "t4_edge");

    // Back-pressure during replay with dropped bytes, then saturation.
    stalledFrame(8'h40, 3, "t5");
    stalledFrame(8'hC0, 14, "t5_sat");

    // Reset during payload.
    startFrame();
    applyStimulus(SOF);
    applyStimulus(8'h50);
    applyStimulus(8'h04);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    checkOutput("t6a_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkResetValues("t6a");
    @(negedge clk);
    rst_n = 1'b1;
    ovrModel = 0;
    @(posedge clk); #1;
    idle(3);
    checkOutput("t6a_no_pulse", okCnt + errCnt, 0);

    // Reset during a stalled replay.
    startFrame();
    wr_ready = 1'b0;
    applyStimulus(SOF);
    applyStimulus(8'h60);
    applyStimulus(8'h01);
    applyStimulus(8'hAB);
    applyStimulus(8'h60 ^ 8'h01 ^ 8'hAB);
    checkOutput("t6b_replay", wr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkResetValues("t6b");
    wr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);
    checkOutput("t6b_lost", obsQ.size() + okCnt + errCnt, 0);
    runFrame(8'hFF, 8'd2, 1'b0, 1'b0, "t6_wrap");

    // Randomized frames with random back-pressure.
    for (int f = 0; f < 40; f++) begin
      runFrame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 10)),
               ($urandom_range(0, 3) == 0), 1'b1, "rnd");
    end

    checkOutput("ok_err_exclusive", bothCnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
